tt_pin_driver: RTL and testbench

Host-side driver for the Tiny Tapeout user-project pin interface. It drives `ui_in`, `uio_in`, `ena` and `rst_n` of a `tt_um_*` design under test from a command stream. After a programmable wait it samples `uo_out` and the resolved `uio` pins and returns them on a response stream. It is the active counterpart of the pin bundle the user project exposes, used for on-chip self-test and FPGA bring-up harnesses.

---
 rtl/tt_pin_driver_pkg.sv | 23 ++
 rtl/tt_pin_driver_timer.sv | 28 ++
 rtl/tt_pin_driver.sv | 137 +++++++++++++
 tb/tb_tt_pin_driver.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_pin_driver_pkg.sv
// Shared types for the Tiny Tapeout pin driver: opcodes, controller states, default wait width.
package tt_pin_driver_pkg;

  localparam int unsigned WAIT_W_DEFAULT = 8;

  // Opcodes 5..7 are all treated as NOP; only the first is named.
  typedef enum logic [2:0] {
    OP_SET_UI    = 3'd0,
    OP_SET_UIO   = 3'd1,
    OP_SAMPLE    = 3'd2,
    OP_RST_PULSE = 3'd3,
    OP_SET_ENA   = 3'd4,
    OP_NOP       = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_PULSE = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/tt_pin_driver_timer.sv
// Loadable down-counter shared by the SAMPLE wait and the reset pulse.
module tt_pin_driver_timer
  import tt_pin_driver_pkg::*;
#(
  parameter int unsigned WAIT_W = WAIT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WAIT_W-1:0] load_value,
  input  logic              dec,
  output logic [WAIT_W-1:0] value,
  output logic              zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (dec) begin
      value <= value - 1'b1;
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/tt_pin_driver.sv
// Command-stream driver for a tt_um_* pin bundle with sampled response stream.
// Optional uio contention detection: define TT_PIN_DRIVER_CONTENTION_EN.
module tt_pin_driver
  import tt_pin_driver_pkg::*;
#(
  parameter int unsigned WAIT_W = WAIT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [7:0]        cmd_data,
  input  logic [WAIT_W-1:0] cmd_arg,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [7:0]        rsp_uo,
  output logic [7:0]        rsp_uio,
  output logic [7:0]        dut_ui_in,
  output logic [7:0]        dut_uio_in,
  input  logic [7:0]        dut_uo_out,
  input  logic [7:0]        dut_uio_out,
  input  logic [7:0]        dut_uio_oe,
  output logic              dut_ena,
  output logic              dut_rst_n,
  output logic              contention
);

  state_e            state;
  op_e               op;
  logic              accept;
  logic [7:0]        uio_val;
  logic [7:0]        uio_mask;
  logic [7:0]        arg_mask;
  logic              tmr_load;
  logic              tmr_dec;
  logic              tmr_zero;
  logic [WAIT_W-1:0] tmr_value;

  // The drive mask is the low byte of cmd_arg, zero-extended for narrow WAIT_W.
  generate
    if (WAIT_W >= 8) begin : g_mask_wide
      assign arg_mask = cmd_arg[7:0];
    end else begin : g_mask_narrow
      assign arg_mask = {{(8 - WAIT_W){1'b0}}, cmd_arg};
    end
  endgenerate

  assign op        = op_e'(cmd_op);
  assign cmd_ready = (state == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign tmr_load  = accept && ((op == OP_SAMPLE) || (op == OP_RST_PULSE));
  assign tmr_dec   = ((state == ST_WAIT) || (state == ST_PULSE)) && (tmr_value != '0);

  tt_pin_driver_timer #(
    .WAIT_W(WAIT_W)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (tmr_load),
    .load_value(cmd_arg),
    .dec       (tmr_dec),
    .value     (tmr_value),
    .zero      (tmr_zero)
  );

  assign dut_uio_in = uio_val & uio_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      dut_ui_in <= '0;
      uio_val   <= '0;
      uio_mask  <= '0;
      dut_ena   <= 1'b0;
      dut_rst_n <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_uo    <= '0;
      rsp_uio   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            case (op)
              OP_SET_UI:    dut_ui_in <= cmd_data;
              OP_SET_UIO: begin
                uio_val  <= cmd_data;
                uio_mask <= arg_mask;
              end
              OP_SAMPLE:    state <= ST_WAIT;
              OP_RST_PULSE: begin
                dut_rst_n <= 1'b0;
                state     <= ST_PULSE;
              end
              OP_SET_ENA:   dut_ena <= cmd_data[0];
              default:      ;
            endcase
          end
        end
        ST_WAIT: begin
          if (tmr_zero) begin
            rsp_uo    <= dut_uo_out;
            rsp_uio   <= (dut_uio_out & dut_uio_oe) | (dut_uio_in & ~dut_uio_oe);
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end
        end
        ST_PULSE: begin
          if (tmr_zero) begin
            dut_rst_n <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef TT_PIN_DRIVER_CONTENTION_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      contention <= 1'b0;
    end else if (|(uio_mask & dut_uio_oe)) begin
      contention <= 1'b1;
    end
  end
`else
  assign contention = 1'b0;
`endif

endmodule

// File: tb/tb_tt_pin_driver.sv
// Directed bench for tt_pin_driver with a DUT model that echoes uo_out = ui_in.
module tb_tt_pin_driver;

  localparam int unsigned WAIT_W = 8;
`ifdef TT_PIN_DRIVER_CONTENTION_EN
  localparam bit CONT_EN = 1'b1;
`else
  localparam bit CONT_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [2:0]        cmd_op = '0;
  logic [7:0]        cmd_data = '0;
  logic [WAIT_W-1:0] cmd_arg = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [7:0]        rsp_uo;
  logic [7:0]        rsp_uio;
  logic [7:0]        dut_ui_in;
  logic [7:0]        dut_uio_in;
  logic [7:0]        dut_uo_out;
  logic [7:0]        dut_uio_out = '0;
  logic [7:0]        dut_uio_oe = '0;
  logic              dut_ena;
  logic              dut_rst_n;
  logic              contention;

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign dut_uo_out = dut_ui_in;

  tt_pin_driver #(.WAIT_W(WAIT_W)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .cmd_arg    (cmd_arg),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_uo     (rsp_uo),
    .rsp_uio    (rsp_uio),
    .dut_ui_in  (dut_ui_in),
    .dut_uio_in (dut_uio_in),
    .dut_uo_out (dut_uo_out),
    .dut_uio_out(dut_uio_out),
    .dut_uio_oe (dut_uio_oe),
    .dut_ena    (dut_ena),
    .dut_rst_n  (dut_rst_n),
    .contention (contention)
  );

  // Waits (bounded) for cmd_ready, presents one command for one edge; returns at accept edge + 1.
  task automatic send_cmd(input logic [2:0] op, input logic [7:0] data,
                          input logic [WAIT_W-1:0] arg, output bit ok);
    int unsigned n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    ok = cmd_ready;
    if (ok) begin
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      cmd_arg   = arg;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (dut_rst_n !== 1'b0) begin bad++; $display("FAIL reset_dut_rst_n got=%b exp=0", dut_rst_n); end
    total++; if (dut_ena !== 1'b0) begin bad++; $display("FAIL reset_dut_ena got=%b exp=0", dut_ena); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    total++; if ({dut_ui_in, dut_uio_in, rsp_uo, rsp_uio} !== 32'h0) begin
      bad++; $display("FAIL reset_data got=%h exp=00000000", {dut_ui_in, dut_uio_in, rsp_uo, rsp_uio});
    end
    total++; if (contention !== 1'b0) begin bad++; $display("FAIL reset_contention got=%b exp=0", contention); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (dut_rst_n !== 1'b0) begin bad++; $display("FAIL held_in_reset got=%b exp=0", dut_rst_n); end
  endtask

  task automatic test_rst_pulse();
    bit ok;
    send_cmd(3'd3, 8'h00, 8'd0, ok);
    total++; if (!ok) begin bad++; $display("FAIL pulse0_accept timeout"); end
    total++; if (dut_rst_n !== 1'b0) begin bad++; $display("FAIL pulse0_low got=%b exp=0", dut_rst_n); end
    @(posedge clk); #1;
    total++; if (dut_rst_n !== 1'b1) begin bad++; $display("FAIL pulse0_release got=%b exp=1", dut_rst_n); end
    send_cmd(3'd3, 8'h00, 8'd3, ok);
    total++; if (!ok) begin bad++; $display("FAIL pulse3_accept timeout"); end
    total++; if (dut_rst_n !== 1'b0) begin bad++; $display("FAIL pulse3_edge0 got=%b exp=0", dut_rst_n); end
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL pulse3_busy got=%b exp=0", cmd_ready); end
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      total++;
      if (dut_rst_n !== ((k == 4) ? 1'b1 : 1'b0)) begin
        bad++; $display("FAIL pulse3_edge%0d got=%b exp=%b", k, dut_rst_n, (k == 4));
      end
    end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL pulse3_idle got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_ena();
    bit ok;
    send_cmd(3'd4, 8'h01, 8'd0, ok);
    total++; if (dut_ena !== 1'b1) begin bad++; $display("FAIL ena_set got=%b exp=1 ok=%b", dut_ena, ok); end
    send_cmd(3'd4, 8'h02, 8'd0, ok);
    total++; if (dut_ena !== 1'b0) begin bad++; $display("FAIL ena_bit0_only got=%b exp=0 ok=%b", dut_ena, ok); end
    send_cmd(3'd4, 8'h01, 8'd0, ok);
    total++; if (dut_ena !== 1'b1) begin bad++; $display("FAIL ena_reset got=%b exp=1 ok=%b", dut_ena, ok); end
  endtask

  task automatic test_sample_echo();
    bit ok;
    rsp_ready = 1'b0;
    send_cmd(3'd0, 8'hA5, 8'd0, ok);
    total++; if (dut_ui_in !== 8'hA5) begin bad++; $display("FAIL set_ui got=%h exp=a5 ok=%b", dut_ui_in, ok); end
    send_cmd(3'd2, 8'h00, 8'd2, ok);
    total++; if (!ok) begin bad++; $display("FAIL sample_accept timeout"); end
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      total++;
      if (rsp_valid !== ((k == 3) ? 1'b1 : 1'b0)) begin
        bad++; $display("FAIL sample_latency_edge%0d got=%b exp=%b", k, rsp_valid, (k == 3));
      end
    end
    total++; if (rsp_uo !== 8'hA5) begin bad++; $display("FAIL sample_uo got=%h exp=a5", rsp_uo); end
    total++; if (rsp_uio !== 8'h00) begin bad++; $display("FAIL sample_uio got=%h exp=00", rsp_uio); end
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL sample_release got=rdy%b/vld%b exp=rdy1/vld0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_uio_backpressure();
    bit ok;
    rsp_ready   = 1'b0;
    send_cmd(3'd1, 8'hFF, 8'h0F, ok);
    total++; if (dut_uio_in !== 8'h0F) begin bad++; $display("FAIL set_uio got=%h exp=0f ok=%b", dut_uio_in, ok); end
    dut_uio_oe  = 8'hF0;
    dut_uio_out = 8'h30;
    send_cmd(3'd2, 8'h00, 8'd0, ok);
    @(posedge clk); #1;
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL uio_sample_valid got=%b exp=1 ok=%b", rsp_valid, ok); end
    total++; if (rsp_uio !== 8'h3F) begin bad++; $display("FAIL uio_resolved got=%h exp=3f", rsp_uio); end
    dut_uio_out = 8'hC0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b1 || rsp_uo !== 8'hA5 || rsp_uio !== 8'h3F || cmd_ready !== 1'b0) begin
        bad++;
        $display("FAIL backpressure_cyc%0d got=vld%b uo%h uio%h rdy%b exp=vld1 uoa5 uio3f rdy0",
                 k, rsp_valid, rsp_uo, rsp_uio, cmd_ready);
      end
    end
    total++; if (contention !== 1'b0) begin bad++; $display("FAIL no_contention got=%b exp=0", contention); end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL backpressure_release got=vld%b rdy%b exp=vld0 rdy1", rsp_valid, cmd_ready);
    end
    dut_uio_oe  = 8'h00;
    dut_uio_out = 8'h00;
  endtask

  task automatic test_nop();
    bit ok;
    send_cmd(3'd6, 8'h5A, 8'hFF, ok);
    total++; if (!ok || cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || dut_ui_in !== 8'hA5 || dut_uio_in !== 8'h0F) begin
      bad++; $display("FAIL nop got=rdy%b vld%b ui%h uio%h exp=rdy1 vld0 uia5 uio0f",
                      cmd_ready, rsp_valid, dut_ui_in, dut_uio_in);
    end
  endtask

  task automatic test_throughput();
    bit ok;
    int unsigned c0;
    rsp_ready = 1'b1;
    send_cmd(3'd2, 8'h00, 8'd1, ok);
    c0 = cyc;
    send_cmd(3'd2, 8'h00, 8'd1, ok);
    total++; if (!ok || (cyc - c0) != 4) begin
      bad++; $display("FAIL throughput got=%0d exp=4 ok=%b", cyc - c0, ok);
    end
    repeat (4) @(posedge clk);
    #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL throughput_idle got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_max_wait();
    bit ok;
    rsp_ready = 1'b0;
    send_cmd(3'd2, 8'h00, 8'hFF, ok);
    total++; if (!ok) begin bad++; $display("FAIL maxwait_accept timeout"); end
    for (int k = 1; k <= 256; k++) begin
      @(posedge clk); #1;
      if (k == 255) begin
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL maxwait_early got=%b exp=0", rsp_valid); end
      end
      if (k == 256) begin
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL maxwait_capture got=%b exp=1", rsp_valid); end
      end
    end
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_contention();
    bit ok;
    send_cmd(3'd1, 8'h00, 8'h01, ok);
    total++; if (contention !== 1'b0) begin bad++; $display("FAIL cont_before got=%b exp=0 ok=%b", contention, ok); end
    @(negedge clk); dut_uio_oe = 8'h01;
    @(posedge clk); #1;
    total++; if (contention !== CONT_EN) begin bad++; $display("FAIL cont_detect got=%b exp=%b", contention, CONT_EN); end
    @(negedge clk); dut_uio_oe = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    total++; if (contention !== CONT_EN) begin bad++; $display("FAIL cont_sticky got=%b exp=%b", contention, CONT_EN); end
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    rsp_ready = 1'b1;
    send_cmd(3'd2, 8'h00, 8'd20, ok);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (dut_rst_n !== 1'b0 || dut_ena !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL midwait_ctrl got=rst%b ena%b rdy%b vld%b exp=rst0 ena0 rdy1 vld0",
                      dut_rst_n, dut_ena, cmd_ready, rsp_valid);
    end
    total++; if ({dut_ui_in, dut_uio_in, rsp_uo, rsp_uio} !== 32'h0 || contention !== 1'b0) begin
      bad++; $display("FAIL midwait_data got=%h cont=%b exp=00000000 cont=0",
                      {dut_ui_in, dut_uio_in, rsp_uo, rsp_uio}, contention);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) begin
        total++; bad++; $display("FAIL midwait_no_rsp cyc%0d got=1 exp=0", k);
        break;
      end
    end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL midwait_idle got=%b exp=1", cmd_ready); end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rst_pulse();
    test_ena();
    test_sample_echo();
    test_uio_backpressure();
    test_nop();
    test_throughput();
    test_max_wait();
    test_contention();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
